// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath mux select and enable, stalling memory states on ready.
module multicycle_control_unit #(
    parameter int ALUCTRL_W   = 4,
    parameter int IMMSRC_W    = 3,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_funct3,
    input  logic                 i_funct7_5,
    input  logic                 i_eq,
    input  logic                 i_lt,
    input  logic                 i_ltu,
    input  logic                 i_mem_ready,
    output logic                 o_pc_write,
    output logic                 o_ir_write,
    output logic                 o_reg_write,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic [1:0]           o_alu_src_a,
    output logic [1:0]           o_alu_src_b,
    output logic [IMMSRC_W-1:0]  o_imm_src,
    output logic [1:0]           o_result_src,
    output logic [ALUCTRL_W-1:0] o_alu_ctrl,
    output logic                 o_illegal,
    output logic [3:0]           o_state
);

    // state    | meaning
    // FETCH    | read instr at PC, PC += 4 on ready
    // DECODE   | opcode dispatch, branch target into ALUOut
    // MEMADR   | rs1 + imm address for lw/sw
    // MEMREAD  | load data read, waits for ready
    // MEMWB    | load data to rd
    // MEMWRITE | store, waits for ready
    // EXECR    | R-type ALU op
    // EXECI    | I-type ALU op
    // ALUWB    | ALUOut to rd
    // BRANCH   | compare, PC <= target if taken
    // JAL      | PC <= target, ALUOut <= oldPC + 4
    // LUI      | zero + U-imm
    // TRAP     | illegal instruction, held until reset
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t     r_state;
    logic       w_ready;
    logic       w_taken;
    logic [3:0] w_alu_exec;
    logic [2:0] w_imm_dec;
    logic [3:0] w_alu;
    logic [2:0] w_imm;

    assign w_ready = MEM_WAIT_EN ? i_mem_ready : 1'b1;

    always_comb begin
        w_taken = 1'b0;
        case (i_funct3)
            3'b000:  w_taken = i_eq;
            3'b001:  w_taken = ~i_eq;
            3'b100:  w_taken = i_lt;
            3'b101:  w_taken = ~i_lt;
            3'b110:  w_taken = i_ltu;
            3'b111:  w_taken = ~i_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // sub only exists for R-type; addi ignores instr[30]
    always_comb begin
        w_alu_exec = 4'd0;
        case (i_funct3)
            3'b000:  w_alu_exec = (r_state == S_EXECR && i_funct7_5) ? 4'd1 : 4'd0;
            3'b001:  w_alu_exec = 4'd7;
            3'b010:  w_alu_exec = 4'd5;
            3'b011:  w_alu_exec = 4'd6;
            3'b100:  w_alu_exec = 4'd4;
            3'b101:  w_alu_exec = i_funct7_5 ? 4'd9 : 4'd8;
            3'b110:  w_alu_exec = 4'd3;
            default: w_alu_exec = 4'd2;
        endcase
    end

    always_comb begin
        w_imm_dec = 3'd0;
        case (i_opcode)
            OP_STORE:  w_imm_dec = 3'd1;
            OP_BRANCH: w_imm_dec = 3'd2;
            OP_JAL:    w_imm_dec = 3'd3;
            OP_LUI:    w_imm_dec = 3'd4;
            default:   w_imm_dec = 3'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (i_opcode)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:          r_state <= S_EXECR;
                        OP_IALU:           r_state <= S_EXECI;
                        OP_BRANCH:         r_state <= (i_funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                        OP_JAL:            r_state <= S_JAL;
                        OP_LUI:            r_state <= S_LUI;
                        default:           r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   r_state <= (i_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_LUI:      r_state <= S_ALUWB;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode the current state directly so ready/taken act in the same
    // cycle; rst_n gating drops an in-flight write without waiting for a clock.
    always_comb begin
        o_pc_write   = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        w_imm        = 3'd0;
        o_result_src = 2'b00;
        w_alu        = 4'd0;
        o_illegal    = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_read   = 1'b1;
                    o_alu_src_b  = 2'b10;
                    o_result_src = 2'b10;
                    o_ir_write   = w_ready;
                    o_pc_write   = w_ready;
                end
                S_DECODE: begin
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b01;
                    w_imm       = w_imm_dec;
                end
                S_MEMADR: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                    w_imm       = (i_opcode == OP_STORE) ? 3'd1 : 3'd0;
                end
                S_MEMREAD:  o_mem_read = 1'b1;
                S_MEMWB: begin
                    o_reg_write  = 1'b1;
                    o_result_src = 2'b01;
                end
                S_MEMWRITE: o_mem_write = 1'b1;
                S_EXECR: begin
                    o_alu_src_a = 2'b10;
                    w_alu       = w_alu_exec;
                end
                S_EXECI: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                    w_alu       = w_alu_exec;
                end
                S_ALUWB:    o_reg_write = 1'b1;
                S_BRANCH: begin
                    o_alu_src_a = 2'b10;
                    w_alu       = 4'd1;
                    o_pc_write  = w_taken;
                end
                S_JAL: begin
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b10;
                    o_pc_write  = 1'b1;
                end
                S_LUI: begin
                    o_alu_src_a = 2'b11;
                    o_alu_src_b = 2'b01;
                    w_imm       = 3'd4;
                end
                S_TRAP:     o_illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_imm_src  = IMMSRC_W'(w_imm);
    assign o_alu_ctrl = ALUCTRL_W'(w_alu);
    assign o_state    = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table of inputs and
// expected state/outputs, plus hand sequences for trap and reset corner cases.
module tb_multicycle_control_unit;

    logic       clk, rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, eq, lt, ltu, mem_ready;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl, state_o;

    multicycle_control_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
        .i_funct7_5(funct7_5), .i_eq(eq), .i_lt(lt), .i_ltu(ltu), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_ir_write(ir_write), .o_reg_write(reg_write),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_alu_src_a(alu_src_a),
        .o_alu_src_b(alu_src_b), .o_imm_src(imm_src), .o_result_src(result_src),
        .o_alu_ctrl(alu_ctrl), .o_illegal(illegal), .o_state(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] R   = 7'b0110011, I  = 7'b0010011, LW  = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011, JL = 7'b1101111, LUI = 7'b0110111, SYS = 7'b1110011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, e, l, lu, mr;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    logic [6:0] c_op = 7'd0;
    logic [2:0] c_f3 = 3'd0;
    logic       c_f7 = 1'b0, c_eq = 1'b0, c_lt = 1'b0, c_ltu = 1'b0;

    // {state, pc, ir, rw, mrd, mwr, src_a, src_b, imm, res, alu, illegal}
    function automatic logic [22:0] E(input logic [3:0] st, input logic pc, ir, rw, mrd, mwr,
                                      input logic [1:0] sa, sb, input logic [2:0] imm,
                                      input logic [1:0] res, input logic [3:0] alu, input logic ill);
        return {st, pc, ir, rw, mrd, mwr, sa, sb, imm, res, alu, ill};
    endfunction

    function automatic logic [22:0] eF(input logic mr);
        return E(4'd0, mr, mr, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 3'd0, 2'd2, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eD(input logic [2:0] imm);
        return E(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, imm, 2'd0, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eMA(input logic [2:0] imm);
        return E(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, imm, 2'd0, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eMR();
        return E(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eMWB();
        return E(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd1, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eMW();
        return E(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eER(input logic [3:0] alu);
        return E(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, alu, 1'b0);
    endfunction
    function automatic logic [22:0] eEI(input logic [3:0] alu);
        return E(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, alu, 1'b0);
    endfunction
    function automatic logic [22:0] eWB();
        return E(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eBR(input logic t);
        return E(4'd9, t, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, 4'd1, 1'b0);
    endfunction
    function automatic logic [22:0] eJ();
        return E(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 3'd0, 2'd0, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eL();
        return E(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 3'd4, 2'd0, 4'd0, 1'b0);
    endfunction
    function automatic logic [22:0] eT();
        return E(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 4'd0, 1'b1);
    endfunction

    task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        c_op = op; c_f3 = f3; c_f7 = f7;
    endtask
    task automatic cnd(input logic e, input logic l, input logic lu);
        c_eq = e; c_lt = l; c_ltu = lu;
    endtask
    task automatic row(input logic mr, input logic [22:0] ex);
        vec_t v;
        v = '{c_op, c_f3, c_f7, c_eq, c_lt, c_ltu, mr, ex};
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string nm);
        logic [22:0] act;
        @(negedge clk);
        opcode = v.op; funct3 = v.f3; funct7_5 = v.f7;
        eq = v.e; lt = v.l; ltu = v.lu; mem_ready = v.mr;
        #1;
        act = {state_o, pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_a,
               alu_src_b, imm_src, result_src, alu_ctrl, illegal};
        total++;
        if (act !== v.exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, v.exp);
        end
    endtask

    task automatic go(input logic mr, input logic [22:0] ex, input string nm);
        vec_t v;
        v = '{c_op, c_f3, c_f7, c_eq, c_lt, c_ltu, mr, ex};
        apply(v, nm);
    endtask

    task automatic chk_rst(input string nm);
        logic [22:0] act;
        act = {state_o, pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_a,
               alu_src_b, imm_src, result_src, alu_ctrl, illegal};
        total++;
        if (act !== 23'd0) begin
            bad++;
            $display("FAIL %s: got %h want 0", nm, act);
        end
    endtask

    // called right after a check (negedge+1): assert reset mid-cycle, then release
    task automatic pulse_reset(input string nm);
        #2 rst_n = 1'b0;
        #1 chk_rst(nm);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        eq = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;

        cnd(1'b0, 1'b0, 1'b0);
        ins(R, 3'b000, 1'b0);  row(1, eF(1)); row(0, eD(0)); row(1, eER(4'd0)); row(1, eWB());
        ins(R, 3'b000, 1'b1);  row(1, eF(1)); row(1, eD(0)); row(0, eER(4'd1)); row(1, eWB());
        ins(I, 3'b101, 1'b1);  row(1, eF(1)); row(1, eD(0)); row(1, eEI(4'd9)); row(1, eWB());
        ins(I, 3'b000, 1'b1);  row(1, eF(1)); row(1, eD(0)); row(1, eEI(4'd0)); row(1, eWB());
        ins(R, 3'b011, 1'b0);  row(1, eF(1)); row(1, eD(0)); row(1, eER(4'd6)); row(1, eWB());
        ins(R, 3'b101, 1'b0);  row(1, eF(1)); row(1, eD(0)); row(1, eER(4'd8)); row(1, eWB());
        ins(I, 3'b100, 1'b0);  row(1, eF(1)); row(1, eD(0)); row(1, eEI(4'd4)); row(1, eWB());
        ins(R, 3'b111, 1'b0);  row(1, eF(1)); row(1, eD(0)); row(1, eER(4'd2)); row(1, eWB());
        ins(R, 3'b001, 1'b0);  row(1, eF(1)); row(1, eD(0)); row(1, eER(4'd7)); row(1, eWB());
        ins(LW, 3'b010, 1'b0); row(0, eF(0)); row(1, eF(1)); row(1, eD(0)); row(1, eMA(3'd0));
                               row(0, eMR()); row(0, eMR()); row(1, eMR()); row(0, eMWB());
        ins(SW, 3'b010, 1'b0); row(1, eF(1)); row(0, eD(1)); row(0, eMA(3'd1));
                               row(0, eMW()); row(1, eMW());
        ins(BR, 3'b001, 1'b0); cnd(1, 0, 0); row(1, eF(1)); row(1, eD(2)); row(1, eBR(1'b0));
        cnd(0, 0, 0);          row(1, eF(1)); row(1, eD(2)); row(0, eBR(1'b1));
        ins(BR, 3'b111, 1'b0); cnd(1, 1, 0); row(1, eF(1)); row(1, eD(2)); row(1, eBR(1'b1));
        ins(BR, 3'b100, 1'b0); cnd(0, 1, 0); row(1, eF(1)); row(1, eD(2)); row(1, eBR(1'b1));
        ins(BR, 3'b000, 1'b0); cnd(0, 1, 1); row(1, eF(1)); row(1, eD(2)); row(1, eBR(1'b0));
        ins(BR, 3'b110, 1'b0); cnd(1, 1, 0); row(1, eF(1)); row(1, eD(2)); row(1, eBR(1'b0));
        cnd(0, 0, 0);
        ins(JL, 3'b000, 1'b0); row(1, eF(1)); row(1, eD(3)); row(0, eJ()); row(1, eWB());
        ins(LUI, 3'b000, 1'b0); row(1, eF(1)); row(1, eD(4)); row(1, eL()); row(1, eWB());

        #3 chk_rst("reset_init");
        #9 rst_n = 1'b1;

        foreach (tbl[k]) apply(tbl[k], $sformatf("vec[%0d]", k));

        // illegal branch funct3: trap ignores ready and compare flags
        ins(BR, 3'b010, 1'b0); cnd(1, 1, 1);
        go(1, eF(1), "trap_br_fetch"); go(1, eD(2), "trap_br_decode");
        go(1, eT(), "trap_br_0"); go(0, eT(), "trap_br_1"); go(1, eT(), "trap_br_2");
        pulse_reset("trap_br_reset");
        cnd(0, 0, 0);
        ins(SYS, 3'b000, 1'b0);
        go(1, eF(1), "trap_sys_fetch"); go(1, eD(0), "trap_sys_decode");
        go(1, eT(), "trap_sys_0"); go(1, eT(), "trap_sys_1");
        pulse_reset("trap_sys_reset");

        // reset while a store is waiting on memory
        ins(SW, 3'b010, 1'b0);
        go(1, eF(1), "rst_sw_fetch"); go(1, eD(1), "rst_sw_decode");
        go(1, eMA(3'd1), "rst_sw_memadr"); go(0, eMW(), "rst_sw_memwrite");
        pulse_reset("rst_mid_memwrite");
        go(0, eF(0), "post_reset_fetch_wait");
        go(1, eF(1), "post_reset_fetch");
        ins(R, 3'b000, 1'b0);
        go(1, eD(0), "post_reset_decode"); go(1, eER(4'd0), "post_reset_execr");
        go(1, eWB(), "post_reset_aluwb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
